// File: rtl/barrido_display_if.sv
// Bus between the scan controller and its neighbours: value/load/enable
// inputs plus the digit index, nibble and blanking outputs.
interface barrido_display_if;
   logic [15:0] valor;
   logic        carga;
   logic        habilita;
   logic        blank_ceros;
   logic        b0;
   logic        b1;
   logic [3:0]  nibble;
   logic        apagar;
   logic        fin_trama;

   modport master (
      output valor, carga, habilita, blank_ceros,
      input  b0, b1, nibble, apagar, fin_trama
   );

   modport slave (
      input  valor, carga, habilita, blank_ceros,
      output b0, b1, nibble, apagar, fin_trama
   );
endinterface

// File: rtl/barrido_display.sv
// Four-digit hex display scan controller: steps the digit index at a
// programmable rate and swaps in new values only at frame boundaries.
module barrido_display #(
   parameter int unsigned PRESCALE = 50000
) (
   input logic          clk,
   input logic          rst,
   barrido_display_if.slave bus
);

   localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

   logic [PW-1:0] pre;
   logic [1:0]    dig;
   logic [15:0]   mostrado;
   logic [15:0]   pendiente;
   logic          pend_v;
   logic          fin_r;

   logic          paso;
   logic          frontera;
   logic [3:0]    ceros;

   assign paso     = bus.habilita && (pre == PRE_MAX);
   assign frontera = paso && (dig == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre <= '0;
         dig <= '0;
      end else if (bus.habilita) begin
         if (paso) begin
            pre <= '0;
            dig <= dig + 2'd1;
         end else begin
            pre <= pre + PW'(1);
         end
      end
   end

   // A load coinciding with the boundary bypasses staging and drops any older staged value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mostrado  <= '0;
         pendiente <= '0;
         pend_v    <= 1'b0;
         fin_r     <= 1'b0;
      end else begin
         fin_r <= frontera;
         if (frontera) begin
            if (bus.carga) begin
               mostrado <= bus.valor;
            end else if (pend_v) begin
               mostrado <= pendiente;
            end
            pend_v <= 1'b0;
         end else if (bus.carga) begin
            pendiente <= bus.valor;
            pend_v    <= 1'b1;
         end
      end
   end

   // ceros[k]: every nibble from position 3 down to k is zero.
   always_comb begin
      ceros = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         ceros[k] = ((mostrado >> (4 * k)) == 16'd0);
      end
   end

   assign bus.b0        = dig[0];
   assign bus.b1        = dig[1];
   assign bus.nibble    = mostrado[{dig, 2'b00} +: 4];
   assign bus.apagar    = ~bus.habilita | (bus.blank_ceros & (dig != 2'd0) & ceros[dig]);
   assign bus.fin_trama = fin_r;

endmodule

// File: tb/tb_barrido_display.sv
// Scoreboard bench for barrido_display: two instances (PRESCALE=4 and 1)
// share stimulus and are checked against a frame-position reference model.
module tb_barrido_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] valor = '0;
  logic        carga = 1'b0;
  logic        habilita = 1'b0;
  logic        blank_ceros = 1'b0;

  always #5 clk = ~clk;

  barrido_display_if if4 ();
  barrido_display_if if1 ();

  assign if4.valor = valor;
  assign if4.carga = carga;
  assign if4.habilita = habilita;
  assign if4.blank_ceros = blank_ceros;
  assign if1.valor = valor;
  assign if1.carga = carga;
  assign if1.habilita = habilita;
  assign if1.blank_ceros = blank_ceros;

  barrido_display #(.PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  barrido_display #(.PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    int         inst;
    int         cyc;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  // Reference model: a single enabled-cycle position within the frame.
  int          per[2] = '{4, 1};
  int          pos[2];
  logic [15:0] shown[2];
  logic [15:0] staged[2];
  bit          staged_v[2];
  bit          fin[2];

  function automatic void model_reset();
    for (int unsigned i = 0; i < 2; i++) begin
      pos[i] = 0;
      shown[i] = '0;
      staged[i] = '0;
      staged_v[i] = 1'b0;
      fin[i] = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int unsigned i = 0; i < 2; i++) begin
      bit bnd;
      bnd = habilita && (pos[i] == 4 * per[i] - 1);
      fin[i] = bnd;
      if (bnd) begin
        if (carga) shown[i] = valor;
        else if (staged_v[i]) shown[i] = staged[i];
        staged_v[i] = 1'b0;
      end else if (carga) begin
        staged[i] = valor;
        staged_v[i] = 1'b1;
      end
      if (habilita) pos[i] = (pos[i] + 1) % (4 * per[i]);
    end
  endfunction

  function automatic logic [7:0] model_out(input int i);
    int          d;
    logic [1:0]  dd;
    logic [15:0] up;
    bit          ap;
    d  = pos[i] / per[i];
    dd = 2'(d);
    up = shown[i] >> (4 * d);
    ap = !habilita || (blank_ceros && d != 0 && up == 16'd0);
    return {dd[1], dd[0], up[3:0], ap, fin[i]};
  endfunction

  task automatic step(input bit r, input bit h, input bit c,
                      input logic [15:0] v, input bit bz);
    exp_t e;
    @(posedge clk);
    #2;
    cycle++;
    if (!rst) model_edge();
    rst = r;
    if (r) model_reset();
    habilita = h;
    carga = c;
    valor = v;
    blank_ceros = bz;
    for (int unsigned i = 0; i < 2; i++) begin
      e.inst = i;
      e.cyc = cycle;
      e.exp = model_out(i);
      sb.push_back(e);
    end
  endtask

  task automatic check_reset(input string tag);
    logic [7:0] g4, g1, ex;
    #1;
    ex = {1'b0, 1'b0, 4'h0, ~habilita, 1'b0};
    g4 = {if4.b1, if4.b0, if4.nibble, if4.apagar, if4.fin_trama};
    g1 = {if1.b1, if1.b0, if1.nibble, if1.apagar, if1.fin_trama};
    checks++;
    if (g4 !== ex || g1 !== ex) begin
      errors++;
      $display("FAIL reset_state[%s] cyc=%0d got P4=%b P1=%b expected=%b",
               tag, cycle, g4, g1, ex);
    end
  endtask

  task automatic run_to(input int target, input bit bz);
    for (int unsigned k = 0; k < 64 && pos[0] != target; k++)
      step(1'b0, 1'b1, 1'b0, 16'h0, bz);
    checks++;
    if (pos[0] != target) begin
      errors++;
      $display("FAIL wait_expired cyc=%0d pos=%0d target=%0d", cycle, pos[0], target);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t       e;
      logic [7:0] got;
      e = sb.pop_front();
      if (e.inst == 0)
        got = {if4.b1, if4.b0, if4.nibble, if4.apagar, if4.fin_trama};
      else
        got = {if1.b1, if1.b0, if1.nibble, if1.apagar, if1.fin_trama};
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL scan_out[P=%0d] cyc=%0d got b1b0_nib_ap_fin=%b expected=%b",
                 per[e.inst], e.cyc, got, e.exp);
      end
    end
  end

  initial begin
    model_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    check_reset("initial");
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);

    // Load 1A2F early in the first frame
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h1A2F, 1'b0);
    repeat (40) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

    // Leading-zero suppression, 0040 then 0000
    step(1'b0, 1'b1, 1'b1, 16'h0040, 1'b1);
    repeat (36) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'h0000, 1'b1);
    repeat (36) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b1);

    // Boundary collision: stage 1111, then load 2222 on the boundary edge
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    run_to(6, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h1111, 1'b0);
    run_to(14, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h2222, 1'b0);
    repeat (20) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

    // Two loads in one frame: last wins
    run_to(3, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h3333, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h4444, 1'b0);
    repeat (36) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

    // Enable dropped at dig=2, pre=1 for 10 cycles, with a staged load
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h9876, 1'b0);
    run_to(8, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'hABCD, 1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    repeat (30) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

    // Async reset mid-frame discards a staged value
    run_to(5, 1'b0);
    step(1'b0, 1'b1, 1'b1, 16'h5555, 1'b0);
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 16'h0, 1'b0);
    check_reset("mid_frame");
    step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    repeat (24) step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);

    // Randomized traffic
    for (int unsigned n = 0; n < 800; n++) begin
      bit          r, h, c, bz;
      logic [15:0] v;
      r  = ($urandom_range(0, 99) == 0);
      h  = ($urandom_range(0, 7) != 0);
      c  = ($urandom_range(0, 5) == 0);
      bz = ($urandom_range(0, 3) != 0);
      v  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step(r, h, c, v, bz);
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
